// File: rtl/mcc_pkg.sv
// Shared types and constants for the multi-cycle control FSM.
// State encodings, opcode/alu_op constants and the legality helper.
package mcc_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b000100;
  localparam logic [5:0] OP_SW   = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b000111;
  localparam logic [5:0] OP_BEQ  = 6'b000110;
  localparam logic [5:0] OP_SLTI = 6'b000001;

  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b000;

  typedef struct packed {
    logic rtype;
    logic lw;
    logic sw;
    logic addi;
    logic beq;
    logic slti;
    logic illegal;
  } op_class_t;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_SLTI};
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_opcode_class_decode.sv
// Opcode -> one-hot instruction class.
// Bits above the 6-bit encoding must be zero for a legal opcode.
module opcode_class_decode
  import mcc_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] i_op,
  output op_class_t           o_cls
);

  logic       w_hi_zero;
  logic [5:0] w_lo;
  logic       w_legal;

  assign w_hi_zero = ((i_op >> 6) == '0);
  assign w_lo      = i_op[5:0];
  assign w_legal   = w_hi_zero && is_legal(w_lo);

  always_comb begin
    o_cls         = '0;
    o_cls.rtype   = w_legal && (w_lo == OP_R);
    o_cls.lw      = w_legal && (w_lo == OP_LW);
    o_cls.sw      = w_legal && (w_lo == OP_SW);
    o_cls.addi    = w_legal && (w_lo == OP_ADDI);
    o_cls.beq     = w_legal && (w_lo == OP_BEQ);
    o_cls.slti    = w_legal && (w_lo == OP_SLTI);
    o_cls.illegal = !w_legal;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer.
// Define ILLEGAL_TRAP_EN to trap on illegal opcodes instead of NOP.
module multicycle_control_fsm
  import mcc_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                memto_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state_o,
  output logic                trap
);

  state_e              r_state;
  state_e              w_next;
  logic [OPCODE_W-1:0] r_op_q;
  logic [CNT_W-1:0]    r_cnt;
  logic [OPCODE_W-1:0] w_dec_op;
  op_class_t           w_cls;

  logic               w_pc, w_ir, w_rd, w_as, w_mtr;
  logic               w_rw, w_mrd, w_mwr, w_br;
  logic               w_ret, w_trap, w_imm;
  logic [ALUOP_W-1:0] w_aop, w_aop_cls;

  // DECODE classifies the live opcode; later states use the latched one.
  assign w_dec_op = (r_state == S_DECODE) ? opcode : r_op_q;

  opcode_class_decode #(
    .OPCODE_W(OPCODE_W)
  ) u_dec (
    .i_op (w_dec_op),
    .o_cls(w_cls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_op_q  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
      if (w_ret) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    w_imm     = w_cls.lw | w_cls.sw | w_cls.addi | w_cls.slti;
    w_aop_cls = ALUOP_W'(ALU_FUNCT);
    unique case (1'b1)
      w_cls.lw, w_cls.sw, w_cls.addi: w_aop_cls = ALUOP_W'(ALU_ADD);
      w_cls.slti:                     w_aop_cls = ALUOP_W'(ALU_SLT);
      w_cls.beq:                      w_aop_cls = ALUOP_W'(ALU_SUB);
      default:                        w_aop_cls = ALUOP_W'(ALU_FUNCT);
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    w_pc   = 1'b0;
    w_ir   = 1'b0;
    w_rd   = 1'b0;
    w_as   = 1'b0;
    w_mtr  = 1'b0;
    w_rw   = 1'b0;
    w_mrd  = 1'b0;
    w_mwr  = 1'b0;
    w_br   = 1'b0;
    w_ret  = 1'b0;
    w_trap = 1'b0;
    w_aop  = '0;
    case (r_state)
      S_FETCH: begin
        w_pc   = 1'b1;
        w_ir   = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (!w_cls.illegal) w_next = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        else w_next = S_TRAP;
`else
        else w_next = S_FETCH;
`endif
      end
      S_EXEC: begin
        w_as  = w_imm;
        w_aop = w_aop_cls;
        w_br  = w_cls.beq;
        if (w_cls.beq) begin
          w_ret  = 1'b1;
          w_next = S_FETCH;
        end else if (w_cls.lw || w_cls.sw) begin
          w_next = S_MEM;
        end else if (w_cls.rtype || w_cls.addi || w_cls.slti) begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_as   = 1'b1;
        w_aop  = ALUOP_W'(ALU_ADD);
        w_mrd  = w_cls.lw;
        w_mwr  = w_cls.sw;
        w_next = S_MEM;
        if (!(w_cls.lw || w_cls.sw)) begin
          w_next = S_FETCH;
        end else if (mem_ready) begin
          w_ret  = w_cls.sw;
          w_next = w_cls.lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        w_rw   = 1'b1;
        w_rd   = w_cls.rtype;
        w_mtr  = w_cls.lw;
        w_as   = w_imm;
        w_aop  = w_aop_cls;
        w_ret  = 1'b1;
        w_next = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        w_trap = 1'b1;
        w_next = S_TRAP;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  assign pc_write    = w_pc  & ~rst;
  assign ir_write    = w_ir  & ~rst;
  assign reg_dst     = w_rd  & ~rst;
  assign alu_src     = w_as  & ~rst;
  assign memto_reg   = w_mtr & ~rst;
  assign reg_write   = w_rw  & ~rst;
  assign mem_read    = w_mrd & ~rst;
  assign mem_write   = w_mwr & ~rst;
  assign branch      = w_br  & ~rst;
  assign retire      = w_ret & ~rst;
  assign trap        = w_trap & ~rst;
  assign alu_op      = rst ? '0 : w_aop;
  assign instr_count = r_cnt;
  assign state_o     = r_state;

endmodule
